// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2) carry-less multiplier: default field polynomials,
// FSM state encoding and a constant-width helper.
package gf_pkg;

    localparam logic [3:0]  POLY4  = 4'h3;          // x^4+x+1
    localparam logic [7:0]  POLY8  = 8'h1B;         // x^8+x^4+x^3+x+1
    localparam logic [15:0] POLY16 = 16'h002B;      // x^16+x^5+x^3+x+1
    localparam logic [31:0] POLY32 = 32'h0000_008D; // x^32+x^7+x^3+x^2+1

    typedef enum logic [2:0] {
        IDLE,
        MUL0,
        MUL1,
        MUL2,
        COMB,
        REDUCE,
        DONE
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic logic [31:0] default_poly(input int w);
        logic [31:0] p;
        case (w)
            4:       p = {28'h0, POLY4};
            8:       p = {24'h0, POLY8};
            32:      p = POLY32;
            default: p = {16'h0, POLY16};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/clmul_comb.sv
// Purely combinational N x N carry-less multiplier; product is 2N-1 bits.
module clmul_comb #(
    parameter int N = 8
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-2:0] p
);

    always_comb begin
        p = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                p[i+j] = p[i+j] ^ (a[i] & b[j]);
            end
        end
    end

endmodule

// File: rtl/karatsuba_clmul_seq.sv
// Sequential one-level Karatsuba carry-less multiplier with optional bit-serial
// reduction modulo a GF(2^W) field polynomial. One half-width multiplier, three passes.
module karatsuba_clmul_seq
    import gf_pkg::*;
#(
    parameter int             W         = 16,
    parameter logic [W-1:0]   POLY      = W'(default_poly(W)),
    parameter bit             REDUCE_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] prod
);

    localparam int H  = W / 2;
    localparam int KW = clog2(2 * W);
    localparam logic [2*W-1:0] FPOLY = {{(W-1){1'b0}}, 1'b1, POLY};

    state_e           state_q, state_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic             mode_q, mode_d;
    logic [W-1:0]     d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
    logic [2*W-1:0]   p_q, p_d, prod_q, prod_d;
    logic [KW-1:0]    k_q, k_d;

    logic [H-1:0]     mul_a, mul_b;
    logic [W-2:0]     mul_p;
    logic [W-1:0]     mid;
    logic [2*W-1:0]   t;
    logic             accept;

    clmul_comb #(.N(H)) u_clm (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    // Karatsuba recombination: middle term is (d0^d1^d2) shifted by half a word.
    assign mid = d0_q ^ d1_q ^ d2_q;
    assign t   = {d2_q, d0_q} ^ ({{W{1'b0}}, mid} << H);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        d0_d     = d0_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        p_d      = p_q;
        k_d      = k_q;
        prod_d   = prod_q;
        in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
        accept   = in_valid & in_ready;

        case (state_q)
            MUL1: begin
                mul_a = a_q[H-1:0] ^ a_q[W-1:H];
                mul_b = b_q[H-1:0] ^ b_q[W-1:H];
            end
            MUL2: begin
                mul_a = a_q[W-1:H];
                mul_b = b_q[W-1:H];
            end
            default: begin
                mul_a = a_q[H-1:0];
                mul_b = b_q[H-1:0];
            end
        endcase

        case (state_q)
            MUL0: begin
                d0_d    = {1'b0, mul_p};
                state_d = MUL1;
            end
            MUL1: begin
                d1_d    = {1'b0, mul_p};
                state_d = MUL2;
            end
            MUL2: begin
                d2_d    = {1'b0, mul_p};
                state_d = COMB;
            end
            COMB: begin
                p_d = t;
                k_d = KW'(2 * W - 2);
                if (REDUCE_EN && mode_q) begin
                    state_d = REDUCE;
                end else begin
                    prod_d  = t;
                    state_d = DONE;
                end
            end
            REDUCE: begin
                // Clear bit k by folding x^k = x^(k-W) * POLY back into the low half.
                if (p_q[k_q]) p_d = p_q ^ (FPOLY << (k_q - KW'(W)));
                if (k_q == KW'(W)) begin
                    prod_d  = p_d;
                    state_d = DONE;
                end else begin
                    k_d = k_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            a_d     = a;
            b_d     = b;
            mode_d  = mode;
            state_d = MUL0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            d0_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            p_q     <= '0;
            k_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            p_q     <= p_d;
            k_q     <= k_d;
            prod_q  <= prod_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign prod      = prod_q;

endmodule

// File: tb/tb_karatsuba_clmul_seq.sv
// Directed and random checks of the Karatsuba multiplier; a second instance built
// without reduction hardware runs in lockstep on the same stimulus.
module tb_karatsuba_clmul_seq;

    logic        clk, rst, in_valid, mode, out_ready;
    logic [15:0] a, b;
    logic        in_ready, out_valid, in_ready0, out_valid0;
    logic [31:0] prod, prod0;

    int n_vec = 0;
    int n_err = 0;

    karatsuba_clmul_seq #(.W(16), .POLY(16'h002B), .REDUCE_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .prod(prod)
    );

    karatsuba_clmul_seq #(.W(16), .POLY(16'h002B), .REDUCE_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid0),
        .out_ready(out_ready), .prod(prod0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_clmul(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) if (y[i]) r = r ^ ({16'h0, x} << i);
        return r;
    endfunction

    function automatic logic [31:0] ref_reduce(input logic [31:0] p);
        logic [31:0] r;
        logic [31:0] fp;
        r  = p;
        fp = 32'h0001_002B;
        for (int k = 30; k >= 16; k--) if (r[k]) r = r ^ (fp << (k - 16));
        return r;
    endfunction

    // Issue one op, wait for accept, then count edges until out_valid. Leaves out_ready low.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tm,
                          output logic [31:0] res, output logic [31:0] res0, output int lat);
        int guard;
        guard    = 0;
        a        = ta;
        b        = tb_;
        mode     = tm;
        in_valid = 1'b1;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res  = prod;
        res0 = prod0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [31:0] r, r0, held, e;
    logic [15:0] ra, rb;
    logic        rm;
    int          lat;

    initial begin
        rst = 1'b1; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_prod", 64'(prod), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        run_op(16'h0003, 16'h0003, 1'b0, r, r0, lat);
        chk("m0_3x3", 64'(r), 64'h0000_0005);
        chk("m0_3x3_lat", 64'(lat), 64'd4);
        drain();
        chk("idle_after_drain", 64'(out_valid), 64'd0);

        run_op(16'hFFFF, 16'hFFFF, 1'b0, r, r0, lat);
        chk("m0_ffff", 64'(r), 64'h5555_5555);
        drain();
        run_op(16'h8000, 16'h8000, 1'b0, r, r0, lat);
        chk("m0_8000", 64'(r), 64'h4000_0000);
        drain();

        run_op(16'h8000, 16'h8000, 1'b1, r, r0, lat);
        chk("m1_8000", 64'(r), 64'h0000_C10E);
        chk("m1_8000_lat", 64'(lat), 64'd19);
        chk("nored_8000", 64'(r0), 64'h4000_0000);
        drain();
        run_op(16'h0001, 16'h1234, 1'b1, r, r0, lat);
        chk("m1_1x1234", 64'(r), 64'h0000_1234);
        drain();

        // Backpressure then same-edge consume-and-accept
        run_op(16'h00FF, 16'h0101, 1'b0, r, r0, lat);
        held = r;
        chk("bp_first", 64'(r), 64'h0000_FFFF);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_prod_stable", 64'(prod), 64'(held));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        a = 16'h0002; b = 16'h0003; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_busy", 64'(out_valid), 64'd0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b_lat", 64'(lat), 64'd4);
        chk("b2b_prod", 64'(prod), 64'h0000_0006);
        drain();

        // Reset in the middle of reduction (k=20 during the cycle after edge 14)
        a = 16'h8000; b = 16'h8000; mode = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_prod", 64'(prod), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        run_op(16'h0003, 16'h0003, 1'b0, r, r0, lat);
        chk("postrst_3x3", 64'(r), 64'h0000_0005);
        drain();

        // No-reduction build ignores mode
        run_op(16'h8000, 16'h8000, 1'b1, r, r0, lat);
        chk("nored_m1_8000", 64'(r0), 64'h4000_0000);
        chk("nored_valid", 64'(out_valid0), 64'd1);
        drain();

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rm = 1'($urandom);
            run_op(ra, rb, rm, r, r0, lat);
            e = ref_clmul(ra, rb);
            chk("rand_nored", 64'(r0), 64'(e));
            if (rm) e = ref_reduce(e);
            chk("rand_prod", 64'(r), 64'(e));
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
